cpu_bank_reg_mp: RTL and testbench

Parametrised multi-port register bank with integrated write scoreboard: the next-generation successor of the CPU's two-write-port register file. It provides NUM_READ combinational read ports, NUM_WRITE prioritised writeback ports (ALU, MUL, future LSU/FPU lanes), optional same-cycle write-to-read bypass and an optional hardwired zero register. It also tracks in-flight destination registers so the decode stage can stall on RAW hazards without a separate scoreboard. It sits between decode (reads, issue) and the writeback stages, and its bypass output feeds the forwarding unit.

---
 rtl/cpu_bank_reg_mp.sv | 111 +++++++++++
 tb/tb_cpu_bank_reg_mp.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bank_reg_mp.sv
// Multi-port register bank with prioritised writeback, optional bypass/zero register
// and a built-in pending-destination scoreboard for RAW stall detection.
module cpu_bank_reg_mp #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic [NUM_READ*$clog2(NUM_REGS)-1:0]    rd_addr,
    output logic [NUM_READ*REG_WIDTH-1:0]           rd_data,
    output logic [NUM_READ-1:0]                     rd_busy,
    input  logic [NUM_WRITE-1:0]                    wr_en,
    input  logic [NUM_WRITE*$clog2(NUM_REGS)-1:0]   wr_addr,
    input  logic [NUM_WRITE*REG_WIDTH-1:0]          wr_data,
    input  logic                                    issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0]             issue_reg,
    input  logic                                    flush,
    output logic [$clog2(NUM_REGS+1)-1:0]           pending_count,
    output logic                                    wr_conflict
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic [REG_WIDTH-1:0] reg_file [NUM_REGS];
    logic [NUM_REGS-1:0]  pending;
    logic [NUM_REGS-1:0]  pending_nxt;
    logic [NUM_REGS-1:0]  win_valid;
    logic [REG_WIDTH-1:0] win_data [NUM_REGS];
    logic                 conflict_nxt;
    logic [CW-1:0]        count_nxt;

    // Later (higher-index) ports overwrite earlier matches, so the highest index wins.
    // A collision on r0 still raises wr_conflict even though its data is discarded.
    always_comb begin
        win_valid    = '0;
        conflict_nxt = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            logic hit;
            hit         = 1'b0;
            win_data[r] = '0;
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == AW'(r))) begin
                    if (hit) conflict_nxt = 1'b1;
                    hit         = 1'b1;
                    win_data[r] = wr_data[k*REG_WIDTH +: REG_WIDTH];
                end
            end
            win_valid[r] = hit && !((ZERO_REG != 0) && (r == 0));
        end
    end

    // Flush beats issue, and a new producer beats a same-cycle writeback.
    always_comb begin
        pending_nxt = pending;
        count_nxt   = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (flush) begin
                pending_nxt[r] = 1'b0;
            end else if (issue_valid && (issue_reg == AW'(r)) &&
                         !((ZERO_REG != 0) && (r == 0))) begin
                pending_nxt[r] = 1'b1;
            end else if (win_valid[r]) begin
                pending_nxt[r] = 1'b0;
            end
            count_nxt = count_nxt + CW'(pending_nxt[r]);
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int j = 0; j < NUM_READ; j++) begin
            logic [AW-1:0] a;
            a = rd_addr[j*AW +: AW];
            rd_data[j*REG_WIDTH +: REG_WIDTH] = reg_file[a];
            rd_busy[j]                        = pending[a];
            if ((BYPASS != 0) && win_valid[a]) begin
                rd_data[j*REG_WIDTH +: REG_WIDTH] = win_data[a];
                rd_busy[j]                        = 1'b0;
            end
            if ((ZERO_REG != 0) && (a == '0)) begin
                rd_data[j*REG_WIDTH +: REG_WIDTH] = '0;
                rd_busy[j]                        = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                reg_file[r] <= '0;
            end
            pending       <= '0;
            pending_count <= '0;
            wr_conflict   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (win_valid[r]) reg_file[r] <= win_data[r];
            end
            pending       <= pending_nxt;
            pending_count <= count_nxt;
            wr_conflict   <= conflict_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_bank_reg_mp.sv
// Bench for cpu_bank_reg_mp: a bypass and a non-bypass instance share stimulus and are
// compared each cycle against an array-based reference model, plus directed checks.
module tb_cpu_bank_reg_mp;

    localparam int RW  = 32;
    localparam int NR  = 32;
    localparam int NWR = 2;
    localparam int NRD = 2;
    localparam int AW  = 5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_bp, rd_data_nb;
    logic [1:0]  rd_busy_bp, rd_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        flush;
    logic [5:0]  cnt_bp, cnt_nb;
    logic        conf_bp, conf_nb;

    always #5 clock = ~clock;

    cpu_bank_reg_mp #(.BYPASS(1)) dut (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_bp),
        .rd_busy(rd_busy_bp), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .flush(flush),
        .pending_count(cnt_bp), .wr_conflict(conf_bp)
    );

    cpu_bank_reg_mp #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .flush(flush),
        .pending_count(cnt_nb), .wr_conflict(conf_nb)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_regs [NR];
    bit          m_pend [NR];
    int          m_count;
    bit          m_conf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Highest-index enabled port addressing r; r0 never has a winner.
    task automatic find_win(input int r, output bit found, output logic [31:0] d);
        found = 1'b0;
        d     = '0;
        if (r == 0) return;
        for (int k = NWR - 1; k >= 0; k--) begin
            if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == r) begin
                found = 1'b1;
                d     = wr_data[k*RW +: RW];
                return;
            end
        end
    endtask

    task automatic model_check();
        for (int j = 0; j < NRD; j++) begin
            int          a;
            bit          f;
            logic [31:0] d, exp_nb, exp_bp;
            bit          busy_nb, busy_bp;
            a = int'(rd_addr[j*AW +: AW]);
            find_win(a, f, d);
            exp_nb  = (a == 0) ? 32'h0 : m_regs[a];
            busy_nb = (a == 0) ? 1'b0 : m_pend[a];
            exp_bp  = f ? d : exp_nb;
            busy_bp = f ? 1'b0 : busy_nb;
            check_val($sformatf("rd_data_bp[%0d] r%0d", j, a), rd_data_bp[j*RW +: RW], exp_bp);
            check_val($sformatf("rd_data_nb[%0d] r%0d", j, a), rd_data_nb[j*RW +: RW], exp_nb);
            check_val($sformatf("rd_busy_bp[%0d] r%0d", j, a), 32'(rd_busy_bp[j]), 32'(busy_bp));
            check_val($sformatf("rd_busy_nb[%0d] r%0d", j, a), 32'(rd_busy_nb[j]), 32'(busy_nb));
        end
        check_val("pending_count_bp", 32'(cnt_bp), 32'(m_count));
        check_val("pending_count_nb", 32'(cnt_nb), 32'(m_count));
        check_val("wr_conflict_bp", 32'(conf_bp), 32'(m_conf));
        check_val("wr_conflict_nb", 32'(conf_nb), 32'(m_conf));
    endtask

    task automatic model_update();
        int wcnt [NR];
        if (!reset_n) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 1'b0;
            end
            m_count = 0;
            m_conf  = 1'b0;
            return;
        end
        for (int r = 0; r < NR; r++) wcnt[r] = 0;
        for (int k = 0; k < NWR; k++) if (wr_en[k]) wcnt[int'(wr_addr[k*AW +: AW])]++;
        m_conf = 1'b0;
        for (int r = 0; r < NR; r++) if (wcnt[r] >= 2) m_conf = 1'b1;
        m_count = 0;
        for (int r = 0; r < NR; r++) begin
            bit          f;
            logic [31:0] d;
            find_win(r, f, d);
            if (f) m_regs[r] = d;
            if (flush)                                              m_pend[r] = 1'b0;
            else if (issue_valid && int'(issue_reg) == r && r != 0) m_pend[r] = 1'b1;
            else if (f)                                             m_pend[r] = 1'b0;
            if (m_pend[r]) m_count++;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        if (chk_en) model_check();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        issue_valid = 1'b0;
        issue_reg   = '0;
        flush       = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        m_count = 0;
        m_conf  = 1'b0;
        idle();
        rd_addr = {5'd4, 5'd3};
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        #2;
        check_val("reset count", 32'(cnt_bp), 32'h0);
        check_val("reset conflict", 32'(conf_bp), 32'h0);
        check_val("reset rd_data r3", rd_data_bp[31:0], 32'h0);
        check_val("reset rd_busy", 32'(rd_busy_bp), 32'h0);

        // r1..r4 through port 0, then an attempted write to r0
        for (int i = 1; i <= 4; i++) begin
            wr_en   = 2'b01;
            wr_addr = {5'd0, 5'(i)};
            wr_data = {32'h0, 32'(i * 32'h11)};
            cycle();
        end
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'h0, 32'hDEAD};
        cycle();
        idle();
        rd_addr = {5'd2, 5'd1};
        #2;
        check_val("read r1", rd_data_nb[31:0], 32'h11);
        check_val("read r2", rd_data_nb[63:32], 32'h22);
        cycle();
        rd_addr = {5'd0, 5'd4};
        #2;
        check_val("read r4", rd_data_bp[31:0], 32'h44);
        check_val("read r0 bp", rd_data_bp[63:32], 32'h0);
        check_val("read r0 nb", rd_data_nb[63:32], 32'h0);
        check_val("count after writes", 32'(cnt_bp), 32'h0);
        cycle();

        // colliding writes to r5
        wr_en   = 2'b11;
        wr_addr = {5'd5, 5'd5};
        wr_data = {32'hBBBB, 32'hAAAA};
        rd_addr = {5'd0, 5'd5};
        #2;
        check_val("collide bypass r5", rd_data_bp[31:0], 32'hBBBB);
        check_val("collide nb r5 old", rd_data_nb[31:0], 32'h0);
        cycle();
        idle();
        #2;
        check_val("collide array r5", rd_data_nb[31:0], 32'hBBBB);
        check_val("wr_conflict set", 32'(conf_bp), 32'h1);
        cycle();
        #2;
        check_val("wr_conflict clear", 32'(conf_bp), 32'h0);
        cycle();

        // issue then writeback r7
        issue_valid = 1'b1;
        issue_reg   = 5'd7;
        rd_addr     = {5'd0, 5'd7};
        #2;
        check_val("issue same-cycle busy", 32'(rd_busy_bp[0]), 32'h0);
        cycle();
        idle();
        #2;
        check_val("r7 busy after issue", 32'(rd_busy_bp[0]), 32'h1);
        check_val("count after issue r7", 32'(cnt_bp), 32'h1);
        cycle();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd7};
        wr_data = {32'h0, 32'h77};
        #2;
        check_val("r7 wb bypass data", rd_data_bp[31:0], 32'h77);
        check_val("r7 wb bypass busy", 32'(rd_busy_bp[0]), 32'h0);
        check_val("r7 wb nb busy", 32'(rd_busy_nb[0]), 32'h1);
        cycle();
        idle();
        #2;
        check_val("count after wb r7", 32'(cnt_bp), 32'h0);
        check_val("r7 nb data", rd_data_nb[31:0], 32'h77);
        cycle();

        // issue and writeback r9 in the same cycle: issue wins
        issue_valid = 1'b1;
        issue_reg   = 5'd9;
        wr_en       = 2'b10;
        wr_addr     = {5'd9, 5'd0};
        wr_data     = {32'h99, 32'h0};
        rd_addr     = {5'd0, 5'd9};
        cycle();
        idle();
        #2;
        check_val("r9 pending", 32'(rd_busy_bp[0]), 32'h1);
        check_val("r9 data", rd_data_nb[31:0], 32'h99);
        check_val("count r9", 32'(cnt_bp), 32'h1);
        cycle();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'h99};
        cycle();
        idle();
        #2;
        check_val("count r9 cleared", 32'(cnt_bp), 32'h0);
        cycle();

        // issue r1,r2,r3 then flush
        for (int i = 1; i <= 3; i++) begin
            issue_valid = 1'b1;
            issue_reg   = 5'(i);
            #2;
            check_val($sformatf("count before issue r%0d", i), 32'(cnt_bp), 32'(i - 1));
            cycle();
        end
        idle();
        flush = 1'b1;
        #2;
        check_val("count before flush", 32'(cnt_bp), 32'h3);
        cycle();
        idle();
        rd_addr = {5'd2, 5'd1};
        #2;
        check_val("count after flush", 32'(cnt_bp), 32'h0);
        check_val("r1 kept", rd_data_nb[31:0], 32'h11);
        check_val("r2 kept", rd_data_nb[63:32], 32'h22);
        cycle();

        // reset while r4 pending
        issue_valid = 1'b1;
        issue_reg   = 5'd4;
        rd_addr     = {5'd0, 5'd4};
        cycle();
        idle();
        #2;
        check_val("r4 busy", 32'(rd_busy_nb[0]), 32'h1);
        check_val("r4 value", rd_data_bp[31:0], 32'h44);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        #2;
        check_val("post-reset count", 32'(cnt_nb), 32'h0);
        check_val("post-reset r4 bp", rd_data_bp[31:0], 32'h0);
        check_val("post-reset r4 nb", rd_data_nb[31:0], 32'h0);
        check_val("post-reset busy", 32'(rd_busy_bp[0]), 32'h0);
        cycle();

        // non-bypass one-cycle write visibility
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd6};
        wr_data = {32'h0, 32'h66};
        rd_addr = {5'd0, 5'd6};
        #2;
        check_val("nb write not yet visible", rd_data_nb[31:0], 32'h0);
        cycle();
        idle();
        #2;
        check_val("nb write visible", rd_data_nb[31:0], 32'h66);
        cycle();

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            reset_n     = ($urandom_range(63) != 0);
            flush       = ($urandom_range(15) == 0);
            issue_valid = 1'($urandom_range(1));
            issue_reg   = ($urandom_range(1) != 0) ? 5'($urandom_range(7)) : 5'($urandom);
            wr_en       = 2'($urandom);
            for (int k = 0; k < NWR; k++) begin
                wr_addr[k*AW +: AW] = ($urandom_range(1) != 0) ? 5'($urandom_range(7)) : 5'($urandom);
            end
            wr_data = {$urandom, $urandom};
            for (int j = 0; j < NRD; j++) begin
                case ($urandom_range(2))
                    0:       rd_addr[j*AW +: AW] = wr_addr[j*AW +: AW];
                    1:       rd_addr[j*AW +: AW] = 5'($urandom_range(7));
                    default: rd_addr[j*AW +: AW] = 5'($urandom);
                endcase
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
